// File: rtl/fanout_collector.sv
// fanout_collector: captures a WIDTH-bit leaf frame and serialises it LSB first.
// Define FANOUT_COLLECTOR_CHECK_EN to build the per-group consistency checker.
module fanout_collector #(
  parameter int WIDTH  = 20,
  parameter int GROUPS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in_vec,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [7:0]        frame_cnt,
  output logic              mismatch,
  output logic [GROUPS-1:0] err_group
);
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic {IDLE, SHIFT} state_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             cap, xfer;
  assign cap  = in_valid && in_ready;
  assign xfer = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = in_valid ? SHIFT : IDLE;
    else                 state_d = (xfer && out_last) ? IDLE : SHIFT;
  end
  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == SHIFT;
    out_last  = out_valid && idx_q == IW'(WIDTH - 1);
    out_bit   = sr_q[0];
  end
  always_comb begin
    sr_d  = cap ? in_vec : xfer ? sr_q >> 1 : sr_q;
    idx_d = cap ? '0 : xfer ? idx_q + 1'b1 : idx_q;
    cnt_d = (xfer && out_last) ? cnt_q + 8'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end
  assign frame_cnt = cnt_q;
`ifdef FANOUT_COLLECTOR_CHECK_EN
  localparam int GS = WIDTH / GROUPS;
  logic [GROUPS-1:0] err_q, err_d;
  // A group is consistent only when its leaves are all 0 or all 1.
  always_comb begin
    err_d = err_q;
    for (int g = 0; g < GROUPS; g++)
      if (cap) err_d[g] = !(&in_vec[g*GS +: GS] || ~|in_vec[g*GS +: GS]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end
  assign err_group = err_q;
  assign mismatch  = |err_q;
`else
  assign err_group = '0;
  assign mismatch  = 1'b0;
`endif
endmodule

// File: doc/fanout_collector.md
FANOUT_COLLECTOR -- requirements
Module: fanout_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 20: number of parallel fanout leaf lines captured per frame.
REQ-002 SHALL have parameter GROUPS, default 4: number of equal buffer groups; WIDTH SHALL be an integer multiple of GROUPS (group size GS = WIDTH/GROUPS, default 5).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_vec  input  WIDTH  parallel leaf values; bit 0 = first leaf (out1).
REQ-006 SHALL have port in_valid  input  1  in_vec is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block can capture a frame.
REQ-008 SHALL have port out_bit  output  1  serial data, bit 0 of the frame first.
REQ-009 SHALL have port out_valid  output  1  out_bit is valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_bit.
REQ-011 SHALL have port out_last  output  1  current out_bit is bit WIDTH-1 of the frame.
REQ-012 SHALL have port frame_cnt  output  8  count of fully transmitted frames.
REQ-013 SHALL have port mismatch  output  1  captured frame has at least one inconsistent group.
REQ-014 SHALL have port err_group  output  GROUPS  per-group inconsistency mask, bit g = group g.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-016 In IDLE, in_ready SHALL be 1 and out_valid 0; in SHIFT, in_ready SHALL be 0.
REQ-017 On in_valid && in_ready, SHALL load in_vec into a WIDTH-bit shift register, clear the bit index, and enter SHIFT on the next cycle.
REQ-018 First out_valid SHALL assert exactly one cycle after the capture handshake.
REQ-019 In SHIFT, out_valid SHALL be 1 and out_bit SHALL equal shift register bit 0.
REQ-020 On out_valid && out_ready, SHALL shift right by one and increment the index.
REQ-021 While out_valid && !out_ready, out_bit, out_last and the index SHALL hold stable.
REQ-022 out_last SHALL be 1 only when the index equals WIDTH-1.
REQ-023 A transfer with out_last SHALL return the FSM to IDLE, increment frame_cnt, and leave at least one IDLE cycle. Minimum frame period is therefore WIDTH+1 cycles.
REQ-024 frame_cnt SHALL wrap from 255 to 0.
REQ-025 in_vec and in_valid SHALL be ignored while in SHIFT.

Reset
REQ-026 rst_n low SHALL immediately force IDLE and clear the shift register, index, frame_cnt, mismatch and err_group. Resulting outputs: in_ready=1, out_valid=0, out_bit=0, out_last=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame without incrementing frame_cnt.
REQ-028 After rst_n deasserts, the first capture SHALL be possible on the first clock edge.

Configuration
REQ-029 Macro FANOUT_COLLECTOR_CHECK_EN SHALL gate the group-consistency checker.
REQ-030 With the macro defined, at each capture err_group[g] SHALL be registered as 1 iff the bits of in_vec[g*GS +: GS] are not all equal.
REQ-031 With the macro defined, mismatch SHALL be the OR of err_group, valid from the cycle after capture, and held until the next capture or reset.
REQ-032 With the macro undefined, mismatch and err_group SHALL be constant 0 and no checker logic SHALL be present.

Verification
REQ-033 in_vec=20'h003E0 capture, out_ready=1 -> serial bits 0,0,0,0,0,1,1,1,1,1,then 10 zeros; out_last on the 20th bit; frame_cnt 0->1; mismatch=0.
REQ-034 in_vec=20'h00001 with CHECK_EN -> mismatch=1 and err_group=4'b0001 from the cycle after capture; without CHECK_EN -> both 0.
REQ-035 out_ready toggled 1,0,0,1 during a frame of 20'hFFFFF -> out_bit=1 held, index advances only on ready cycles, total 20 transfers.
REQ-036 rst_n pulsed low after 7 transfers -> out_valid=0 and in_ready=1 asynchronously; frame_cnt unchanged at 0; the next frame starts from bit 0.
REQ-037 256 back-to-back frames with in_valid held high -> frame_cnt wraps to 0; each frame period is 21 cycles; in_ready is high exactly one cycle per frame.
